// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fc_layer requantizer.
// The FC_RELU_EN macro (see fc_round_sat) switches stage 2 to a ReLU clamp.
package fc_pkg;

    function automatic int fc_acc_width(input int n, input int k);
        return 2 * (n - 1) + k;
    endfunction

    function automatic int fc_sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int fc_sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

    localparam int FC_N       = 8;
    localparam int FC_K       = 3;
    localparam int FC_L       = fc_acc_width(FC_N, FC_K);
    localparam int FC_SAT_MAX = fc_sat_max(FC_N);
    localparam int FC_SAT_MIN = fc_sat_min(FC_N);

    // Stage-2 payload as it leaves the block.
    typedef struct packed {
        logic signed [FC_N-1:0] value;
        logic                   last;
        logic                   sat;
    } fc_payload_t;

endpackage

// File: rtl/fc_round_sat.sv
// Combinational round/shift (stage 1) and saturate (stage 2) arithmetic.
// With FC_RELU_EN defined, negative values are clamped to 0 before saturation.
module fc_round_sat
    import fc_pkg::*;
#(
    parameter int L     = FC_L,
    parameter int N     = FC_N,
    parameter int SHIFT = N - 1
) (
    input  logic signed [L-1:0]     acc_i,
    output logic signed [L-SHIFT:0] r_o,
    input  logic signed [L-SHIFT:0] r_i,
    output logic signed [N-1:0]     act_o,
    output logic                    sat_o
);
    localparam int RW = L - SHIFT + 1;
    localparam int EW = ((RW > N) ? RW : N) + 1;
    localparam logic [L:0] HALF = {{L{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [EW-1:0] MAX_E = EW'(fc_sat_max(N));
    localparam logic signed [EW-1:0] MIN_E = EW'(fc_sat_min(N));

    logic signed [L:0]    sum;
    logic signed [L:0]    shifted;
    logic signed [EW-1:0] r_ext;
    logic signed [EW-1:0] v;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        sum     = $signed({acc_i[L-1], acc_i}) + $signed(HALF);
        shifted = sum >>> SHIFT;
        r_o     = shifted[L-SHIFT:0];
    end

    always_comb begin
        r_ext = {{(EW-RW){r_i[RW-1]}}, r_i};
        v     = r_ext;
`ifdef FC_RELU_EN
        if (v < 0) v = '0;
`endif
        sat_o = 1'b0;
        act_o = v[N-1:0];
        if (v > MAX_E) begin
            act_o = MAX_E[N-1:0];
            sat_o = 1'b1;
        end else if (v < MIN_E) begin
            act_o = MIN_E[N-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fc_requant.sv
// Two-stage valid/ready requantizer: round+shift, then saturate, plus a saturation counter.
// Build option FC_RELU_EN selects a ReLU clamp in stage 2 (see fc_round_sat).
module fc_requant
    import fc_pkg::*;
#(
    parameter int N     = FC_N,   // must equal fc_pkg::FC_N (payload struct width)
    parameter int K     = FC_K,
    parameter int L     = fc_acc_width(N, K),
    parameter int SHIFT = N - 1,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [L-1:0] in_acc,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_act,
    output logic                out_last,
    output logic                out_sat,
    output logic [CW-1:0]       sat_cnt,
    input  logic                sat_clr
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // a producer holding valid keeps its payload stable until that edge.

    logic                   s1_valid_q, s1_valid_d;
    logic signed [L-SHIFT:0] s1_r_q, s1_r_d;
    logic                   s1_last_q, s1_last_d;
    logic                   out_valid_q, out_valid_d;
    fc_payload_t            payload_q, payload_d;
    logic [CW-1:0]          sat_cnt_q, sat_cnt_d;

    logic                   s1_adv, s2_adv;
    logic signed [L-SHIFT:0] r_round;
    logic signed [N-1:0]    act_sat;
    logic                   sat_flag;

    fc_round_sat #(.L(L), .N(N), .SHIFT(SHIFT)) u_round_sat (
        .acc_i (in_acc),
        .r_o   (r_round),
        .r_i   (s1_r_q),
        .act_o (act_sat),
        .sat_o (sat_flag)
    );

    always_comb begin
        s2_adv = !out_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_last_d  = s1_last_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_r_d    = r_round;
                s1_last_d = in_last;
            end
        end

        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                payload_d = '{value: act_sat, last: s1_last_q, sat: sat_flag};
            end
        end

        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready && payload_q.sat && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            payload_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign out_act   = payload_q.value;
    assign out_last  = payload_q.last;
    assign out_sat   = payload_q.sat;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fc_requant.sv
// Bench for fc_requant: table vectors, hand-written corner sequences and a random stream
// checked against an arithmetic reference model. Honours FC_RELU_EN like the design.
module tb_fc_requant;
    localparam int N     = 8;
    localparam int K     = 3;
    localparam int L     = 17;
    localparam int SHIFT = 7;
    localparam int CW    = 4;
    localparam int W     = N + 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [L-1:0] in_acc = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_act;
    logic                out_last;
    logic                out_sat;
    logic [CW-1:0]       sat_cnt;
    logic                sat_clr = 1'b0;

    int   ready_mode = 0;       // 0: stall, 1: always ready, 2: random
    logic rand_rdy = 1'b1;
    assign out_ready = (ready_mode == 2) ? rand_rdy : (ready_mode == 1);

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] held;
    logic         held_v = 1'b0;

    fc_requant #(.N(N), .K(K), .L(L), .SHIFT(SHIFT), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    // ---------------- clock / random ready ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_rdy = ($urandom_range(0, 1) == 1);
    end

    // ---------------- reference model ----------------
    // Round half up then floor-divide by 2^SHIFT, then clamp to the N-bit range.
    function automatic logic [W-1:0] model(input logic signed [L-1:0] acc, input logic last);
        int a;
        int d;
        int r;
        logic s;
        logic [N-1:0] v;
        d = 1 << SHIFT;
        a = int'(acc) + (1 << (SHIFT - 1));
        r = (a >= 0) ? (a / d) : -((-a + d - 1) / d);
        s = 1'b0;
`ifdef FC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) begin
            r = 127;
            s = 1'b1;
        end else if (r < -128) begin
            r = -128;
            s = 1'b1;
        end
        v = r[N-1:0];
        return {v, last, s};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            got = {out_act, out_last, out_sat};
            if (held_v) chk("hold", {21'd0, out_valid, got}, {21'd0, 1'b1, held});
            held_v = out_valid && !out_ready;
            held   = got;
            if (in_valid && in_ready) exp_q.push_back(model(in_acc, in_last));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream", {22'd0, got}, {22'd0, e});
                end
                obs_q.push_back(got);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic signed [L-1:0] a, input logic l);
        bit ok;
        in_valid = 1'b1;
        in_acc   = a;
        in_last  = l;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   acc;
        int   exp_act;
        logic exp_sat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] o;
        logic [9:0]   last_mask;
        logic signed [N-1:0] act;
        bit ok;

        vecs[0] = '{1000, 8, 1'b0};
        vecs[1] = '{-1000, -8, 1'b0};
        vecs[2] = '{64, 1, 1'b0};
        vecs[3] = '{-65, -1, 1'b0};
        vecs[4] = '{16384, 127, 1'b1};
`ifdef FC_RELU_EN
        vecs[5] = '{-65536, 0, 1'b0};
`else
        vecs[5] = '{-65536, -128, 1'b1};
`endif

        // ---- reset values ----
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_act", {24'd0, out_act}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        chk("rst_sat_cnt", {28'd0, sat_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_mode = 1;

        // ---- latency of a single element ----
        send(L'(1000), 1'b0);
        @(negedge clk);
        chk("latency_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_2", {31'd0, out_valid}, 32'd1);
        wait_drain();
        obs_q.delete();

        // ---- table vectors, back to back ----
        foreach (vecs[i]) send(L'(vecs[i].acc), 1'b0);
        wait_drain();
        chk("table_count", obs_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (obs_q.size() == 0) break;
            o = obs_q.pop_front();
            act = o[W-1:2];
            chk($sformatf("table_act_%0d", i), 32'(int'(act)), 32'(vecs[i].exp_act));
            chk($sformatf("table_sat_%0d", i), {31'd0, o[0]}, {31'd0, vecs[i].exp_sat});
        end
`ifdef FC_RELU_EN
        chk("sat_cnt_table", {28'd0, sat_cnt}, 32'd1);
`else
        chk("sat_cnt_table", {28'd0, sat_cnt}, 32'd2);
`endif

        // ---- backpressure: 10 values, last on the 4th and 9th ----
        obs_q.delete();
        ready_mode = 0;
        send(L'($urandom_range(0, 131071)), 1'b0);
        send(L'($urandom_range(0, 131071)), 1'b0);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        ready_mode = 2;
        for (int i = 2; i < 10; i++) send(L'($urandom_range(0, 131071)), (i == 3 || i == 8));
        wait_drain();
        chk("bp_count", obs_q.size(), 32'd10);
        last_mask = '0;
        for (int i = 0; i < 10; i++) begin
            if (obs_q.size() == 0) break;
            o = obs_q.pop_front();
            last_mask[i] = o[1];
        end
        chk("bp_last_mask", {22'd0, last_mask}, 32'h108);

        // ---- counter boundary ----
        ready_mode = 1;
        for (int i = 0; i < 20; i++) send(L'(16384), 1'b0);
        wait_drain();
        chk("sat_cnt_stick", {28'd0, sat_cnt}, 32'd15);
        ready_mode = 0;
        send(L'(16384), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("clr_wait", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        ready_mode = 0;
        chk("sat_clr_priority", {28'd0, sat_cnt}, 32'd0);
        chk("clr_handshake", exp_q.size(), 32'd0);

        // ---- random stream ----
        ready_mode = 2;
        for (int i = 0; i < 60; i++) send(L'($urandom_range(0, 131071)), ($urandom_range(0, 3) == 0));
        wait_drain();

        // ---- reset mid-stream ----
        ready_mode = 0;
        send(L'(3000), 1'b1);
        send(L'(-3000), 1'b0);
        chk("rst_pre_full", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_empty", {31'd0, out_valid}, 32'd0);
        ready_mode = 1;
        send(L'(640), 1'b0);
        @(negedge clk);
        chk("rst_latency_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("rst_latency_2", {31'd0, out_valid}, 32'd1);
        chk("rst_first_act", {24'd0, out_act}, 32'd5);
        wait_drain();
        chk("rst_count", obs_q.size(), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
